// File: rtl/segmented_display_pkg.sv
// Shared types, constants and round-robin search for the display scheduler.
package segmented_display_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int unsigned max_requesters    = 32;
  localparam int unsigned pick_index_width  = 5;
  localparam int unsigned max_pattern_width = 256;

  // Blank display contents; the top takes as many low bits as it needs.
  localparam logic [max_pattern_width-1:0] default_idle_pattern = '0;

  typedef struct packed {
    logic                        found;
    logic [pick_index_width-1:0] idx;
  } pick_t;

  // First requesting index at or after pointer, searching upward with wrap-around.
  function automatic pick_t rr_pick(
    input logic [max_requesters-1:0]   req,
    input logic [pick_index_width-1:0] pointer,
    input int unsigned                 count
  );
    pick_t       result;
    logic [31:0] cand;
    result = '0;
    for (int unsigned k = 0; k < max_requesters; k++) begin
      cand = 32'(pointer) + k;
      if (cand >= count) cand = cand - count;
      if ((k < count) && !result.found && req[cand[pick_index_width-1:0]]) begin
        result.found = 1'b1;
        result.idx   = cand[pick_index_width-1:0];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/segmented_display_scheduler_picker.sv
// Combinational round-robin picker: next requester at or after the pointer.
module round_robin_picker
  import segmented_display_pkg::*;
#(
  parameter int unsigned number_of_requesters = 4
) (
  input  logic [number_of_requesters-1:0]         req,
  input  logic [$clog2(number_of_requesters)-1:0] pointer,
  output logic                                    found,
  output logic [$clog2(number_of_requesters)-1:0] idx
);

  localparam int unsigned index_width = $clog2(number_of_requesters);

  pick_t pick;
  logic  unused_pick_bits;

  assign pick             = rr_pick(max_requesters'(req), pick_index_width'(pointer),
                                    number_of_requesters);
  assign found            = pick.found;
  assign idx              = index_width'(pick.idx);
  assign unused_pick_bits = &{1'b0, pick.idx};

endmodule

// File: rtl/segmented_display_scheduler.sv
// Round-robin time-sharing of one segmented display among several requesters.
module segmented_display_scheduler
  import segmented_display_pkg::*;
#(
  parameter int unsigned number_of_nybbles    = 4,
  parameter int unsigned number_of_requesters = 4,
  parameter int unsigned dwell_cycles         = 50000000,
  parameter int unsigned blank_cycles         = 5000000,
  parameter logic [number_of_nybbles*4-1:0] idle_pattern =
    default_idle_pattern[number_of_nybbles*4-1:0]
) (
  input  logic                                                   clock,
  input  logic                                                   reset,
  input  logic [number_of_requesters-1:0]                        req,
  input  logic [number_of_requesters*number_of_nybbles*4-1:0]    req_data,
  input  logic [number_of_requesters*number_of_nybbles-1:0]      req_dp,
  output logic [number_of_requesters-1:0]                        grant,
  output logic [number_of_requesters-1:0]                        done,
  output logic [$clog2(number_of_requesters)-1:0]                owner,
  output logic [number_of_nybbles*4-1:0]                         data,
  output logic [number_of_nybbles-1:0]                           dp,
  output logic                                                   busy
);

  localparam int unsigned data_width  = number_of_nybbles * 4;
  localparam int unsigned index_width = $clog2(number_of_requesters);
  localparam int unsigned count_max   = (dwell_cycles > blank_cycles) ? dwell_cycles : blank_cycles;
  localparam int unsigned count_width = $clog2(count_max + 1);

  localparam logic [count_width-1:0] dwell_last = count_width'(dwell_cycles - 1);
  localparam logic [count_width-1:0] gap_last   =
    count_width'((blank_cycles == 0) ? 0 : blank_cycles - 1);
  localparam logic [index_width-1:0] last_index = index_width'(number_of_requesters - 1);
  localparam logic [number_of_requesters-1:0] one_hot_base = number_of_requesters'(1);

  state_t                   state;
  logic [index_width-1:0]   pointer;
  logic [count_width-1:0]   counter;

  logic                     pick_found;
  logic [index_width-1:0]   pick_idx;
  logic [index_width-1:0]   next_pointer;

  logic [data_width-1:0]        slice_data [number_of_requesters];
  logic [number_of_nybbles-1:0] slice_dp   [number_of_requesters];

  // Unpack the requester buses into per-requester slices.
  for (genvar r = 0; r < number_of_requesters; r++) begin : g_slice
    assign slice_data[r] = req_data[r*data_width +: data_width];
    assign slice_dp[r]   = req_dp[r*number_of_nybbles +: number_of_nybbles];
  end

  round_robin_picker #(
    .number_of_requesters(number_of_requesters)
  ) u_picker (
    .req    (req),
    .pointer(pointer),
    .found  (pick_found),
    .idx    (pick_idx)
  );

  // Pointer moves past the departing owner so every requester gets a turn.
  assign next_pointer = (owner == last_index) ? '0 : owner + 1'b1;

  // Ownership FSM with dwell/blank counter and registered display outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      pointer <= '0;
      counter <= '0;
      grant   <= '0;
      done    <= '0;
      owner   <= '0;
      busy    <= 1'b0;
      data    <= idle_pattern;
      dp      <= '0;
    end else begin
      done <= '0;
      case (state)
        IDLE: begin
          data <= idle_pattern;
          dp   <= '0;
          if (pick_found) begin
            state   <= SHOW;
            grant   <= one_hot_base << pick_idx;
            owner   <= pick_idx;
            busy    <= 1'b1;
            counter <= '0;
            data    <= slice_data[pick_idx];
            dp      <= slice_dp[pick_idx];
          end
        end
        SHOW: begin
          if ((counter == dwell_last) || !req[owner]) begin
            // Expiry takes precedence over a simultaneous request drop.
            if (counter == dwell_last) done <= one_hot_base << owner;
            grant   <= '0;
            pointer <= next_pointer;
            counter <= '0;
            data    <= idle_pattern;
            dp      <= '0;
            if (blank_cycles == 0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              state <= GAP;
            end
          end else begin
            counter <= counter + 1'b1;
            data    <= slice_data[owner];
            dp      <= slice_dp[owner];
          end
        end
        GAP: begin
          data <= idle_pattern;
          dp   <= '0;
          if (counter == gap_last) begin
            state   <= IDLE;
            busy    <= 1'b0;
            counter <= '0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          grant   <= '0;
          busy    <= 1'b0;
          counter <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_segmented_display_scheduler.sv
// Scoreboard bench for segmented_display_scheduler (3 requesters, dwell 4, blank 2 / blank 0).
module tb_segmented_display_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  req2;
  logic [47:0] req_data;
  logic [11:0] req_dp;

  logic [2:0]  grant, done;
  logic [1:0]  owner;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        busy;

  logic [2:0]  ng_grant, ng_done;
  logic [1:0]  ng_owner;
  logic [15:0] ng_data;
  logic [3:0]  ng_dp;
  logic        ng_busy;

  int assertions = 0;
  int failures   = 0;

  typedef struct packed {
    logic [2:0]  grant;
    logic [2:0]  done;
    logic        busy;
    logic [15:0] data;
    logic [3:0]  dp;
  } exp_t;

  exp_t q[$];

  always #5 clock = ~clock;

  segmented_display_scheduler #(
    .number_of_nybbles(4), .number_of_requesters(3), .dwell_cycles(4), .blank_cycles(2)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .req_data(req_data), .req_dp(req_dp),
    .grant(grant), .done(done), .owner(owner), .data(data), .dp(dp), .busy(busy)
  );

  segmented_display_scheduler #(
    .number_of_nybbles(4), .number_of_requesters(3), .dwell_cycles(4), .blank_cycles(0)
  ) dut_ng (
    .clock(clock), .reset(reset), .req(req2), .req_data(req_data), .req_dp(req_dp),
    .grant(ng_grant), .done(ng_done), .owner(ng_owner), .data(ng_data), .dp(ng_dp),
    .busy(ng_busy)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    req2  = '0;
    q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    req_data = '0;
    req_dp   = '0;
    for (int c = 0; c < 6; c++) begin
      assertions++;
      if (grant !== 3'b000 || busy !== 1'b0 || data !== 16'h0000 || done !== 3'b000 ||
          owner !== 2'd0 || dp !== 4'h0) begin
        failures++;
        $display("FAIL reset_idle c=%0d: grant=%b busy=%b data=%h done=%b owner=%0d dp=%b, want all zero",
                 c, grant, busy, data, done, owner, dp);
      end
    end
    assertions++;
    if (ng_grant !== 3'b000 || ng_busy !== 1'b0 || ng_data !== 16'h0000) begin
      failures++;
      $display("FAIL reset_ng: grant=%b busy=%b data=%h, want 000 0 0000", ng_grant, ng_busy, ng_data);
    end
    req_data[15:0] = 16'h5555;
    req_dp[3:0]    = 4'b1001;
    req = 3'b001;
    tick();
    tick();
    assertions++;
    if (grant !== 3'b001 || data !== 16'h5555 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_pre_show: grant=%b data=%h busy=%b, want 001 5555 1", grant, data, busy);
    end
    reset = 1'b1;
    tick();
    assertions++;
    if (grant !== 3'b000 || done !== 3'b000 || busy !== 1'b0 || owner !== 2'd0 ||
        data !== 16'h0000 || dp !== 4'h0) begin
      failures++;
      $display("FAIL reset_mid_show: grant=%b done=%b busy=%b owner=%0d data=%h dp=%b, want zeros",
               grant, done, busy, owner, data, dp);
    end
    req = '0;
    tick();
    reset = 1'b0;
    tick();
    assertions++;
    if (done !== 3'b000 || grant !== 3'b000) begin
      failures++;
      $display("FAIL reset_after: done=%b grant=%b, want 000 000", done, grant);
    end
  endtask

  task automatic test_round_robin();
    exp_t        e;
    logic [2:0]  prev_grant;
    logic [15:0] cur_data;
    int          held, gap, seen, dones;
    do_reset();
    req_data = {16'h3333, 16'h2222, 16'h1111};
    req_dp   = '0;
    q.push_back('{grant: 3'b001, done: 3'b000, busy: 1'b1, data: 16'h1111, dp: 4'h0});
    q.push_back('{grant: 3'b010, done: 3'b000, busy: 1'b1, data: 16'h2222, dp: 4'h0});
    q.push_back('{grant: 3'b100, done: 3'b000, busy: 1'b1, data: 16'h3333, dp: 4'h0});
    q.push_back('{grant: 3'b001, done: 3'b000, busy: 1'b1, data: 16'h1111, dp: 4'h0});
    req = 3'b111;
    prev_grant = '0;
    cur_data = '0;
    held = 0; gap = 0; seen = 0; dones = 0;
    for (int c = 0; c < 60; c++) begin
      tick();
      if (done !== 3'b000) begin
        dones++;
        assertions++;
        if (done !== prev_grant || grant !== 3'b000) begin
          failures++;
          $display("FAIL rr_done: done=%b grant=%b, want done=%b grant=000", done, grant, prev_grant);
        end
      end
      if (grant !== 3'b000 && prev_grant === 3'b000) begin
        e = q.pop_front();
        assertions++;
        if (grant !== e.grant || data !== e.data || busy !== e.busy) begin
          failures++;
          $display("FAIL rr_grant: grant=%b data=%h busy=%b, want %b %h %b",
                   grant, data, busy, e.grant, e.data, e.busy);
        end
        if (seen > 0) begin
          assertions++;
          if (gap != 3) begin
            failures++;
            $display("FAIL rr_gap: got %0d idle cycles, want 3", gap);
          end
        end
        seen++;
        held = 0;
        gap = 0;
        cur_data = e.data;
      end
      if (grant !== 3'b000) begin
        held++;
        assertions++;
        if (data !== cur_data) begin
          failures++;
          $display("FAIL rr_data: data=%h, want %h", data, cur_data);
        end
      end else begin
        gap++;
        if (prev_grant !== 3'b000) begin
          assertions++;
          if (held != 4) begin
            failures++;
            $display("FAIL rr_held: held %0d cycles, want 4", held);
          end
        end
      end
      prev_grant = grant;
      if (q.size() == 0) break;
    end
    assertions++;
    if (q.size() != 0 || dones != 3) begin
      failures++;
      $display("FAIL rr_complete: %0d grants pending, %0d done pulses, want 0 and 3", q.size(), dones);
    end
    req = '0;
  endtask

  task automatic test_sole_requester();
    int last_done, ndone;
    do_reset();
    req = 3'b010;
    last_done = -1;
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      assertions++;
      if ((grant !== 3'b000 && grant !== 3'b010) || owner !== 2'd1) begin
        failures++;
        $display("FAIL sole_grant c=%0d: grant=%b owner=%0d, want 010/000 and 1", c, grant, owner);
      end
      if (done !== 3'b000) begin
        ndone++;
        assertions++;
        if (done !== 3'b010 || (last_done >= 0 && c - last_done != 7)) begin
          failures++;
          $display("FAIL sole_done c=%0d: done=%b interval=%0d, want 010 and 7", c, done, c - last_done);
        end
        last_done = c;
      end
    end
    assertions++;
    if (ndone != 6) begin
      failures++;
      $display("FAIL sole_count: %0d done pulses, want 6", ndone);
    end
    req = '0;
  endtask

  task automatic test_abort();
    exp_t e;
    do_reset();
    req_data = {16'h0C0C, 16'h0B0B, 16'h0A0A};
    req_dp   = '0;
    q.push_back('{grant: 3'b001, done: 3'b000, busy: 1'b1, data: 16'h0A0A, dp: 4'h0});
    q.push_back('{grant: 3'b001, done: 3'b000, busy: 1'b1, data: 16'h0A0A, dp: 4'h0});
    q.push_back('{grant: 3'b000, done: 3'b000, busy: 1'b1, data: 16'h0000, dp: 4'h0});
    q.push_back('{grant: 3'b000, done: 3'b000, busy: 1'b1, data: 16'h0000, dp: 4'h0});
    q.push_back('{grant: 3'b000, done: 3'b000, busy: 1'b0, data: 16'h0000, dp: 4'h0});
    q.push_back('{grant: 3'b010, done: 3'b000, busy: 1'b1, data: 16'h0B0B, dp: 4'h0});
    req = 3'b011;
    for (int i = 0; i < 6; i++) begin
      tick();
      e = q.pop_front();
      assertions++;
      if (grant !== e.grant || done !== e.done || busy !== e.busy || data !== e.data) begin
        failures++;
        $display("FAIL abort step %0d: grant=%b done=%b busy=%b data=%h, want %b %b %b %h",
                 i, grant, done, busy, data, e.grant, e.done, e.busy, e.data);
      end
      if (i == 1) req = 3'b010;
    end
    req = '0;
  endtask

  task automatic test_live_tracking();
    exp_t e;
    do_reset();
    req_data = {16'hABCD, 16'h2222, 16'h1111};
    req_dp   = '0;
    q.push_back('{grant: 3'b100, done: 3'b000, busy: 1'b1, data: 16'hABCD, dp: 4'b0000});
    q.push_back('{grant: 3'b100, done: 3'b000, busy: 1'b1, data: 16'hABCD, dp: 4'b0000});
    q.push_back('{grant: 3'b100, done: 3'b000, busy: 1'b1, data: 16'h1234, dp: 4'b0101});
    req = 3'b100;
    for (int i = 0; i < 3; i++) begin
      tick();
      e = q.pop_front();
      assertions++;
      if (grant !== e.grant || data !== e.data || dp !== e.dp) begin
        failures++;
        $display("FAIL live step %0d: grant=%b data=%h dp=%b, want %b %h %b",
                 i, grant, data, dp, e.grant, e.data, e.dp);
      end
      if (i == 1) begin
        req_data[47:32] = 16'h1234;
        req_dp[11:8]    = 4'b0101;
      end
    end
    req = '0;
  endtask

  task automatic test_no_gap();
    exp_t e;
    do_reset();
    req_data = {16'h0303, 16'h0202, 16'h0101};
    req_dp   = '0;
    for (int i = 0; i < 4; i++)
      q.push_back('{grant: 3'b001, done: 3'b000, busy: 1'b1, data: 16'h0101, dp: 4'h0});
    q.push_back('{grant: 3'b000, done: 3'b001, busy: 1'b0, data: 16'h0000, dp: 4'h0});
    q.push_back('{grant: 3'b010, done: 3'b000, busy: 1'b1, data: 16'h0202, dp: 4'h0});
    req2 = 3'b011;
    for (int i = 0; i < 6; i++) begin
      tick();
      e = q.pop_front();
      assertions++;
      if (ng_grant !== e.grant || ng_done !== e.done || ng_busy !== e.busy || ng_data !== e.data) begin
        failures++;
        $display("FAIL nogap step %0d: grant=%b done=%b busy=%b data=%h, want %b %b %b %h",
                 i, ng_grant, ng_done, ng_busy, ng_data, e.grant, e.done, e.busy, e.data);
      end
    end
    req2 = '0;
  endtask

  initial begin
    reset    = 1'b1;
    req      = '0;
    req2     = '0;
    req_data = '0;
    req_dp   = '0;
    test_reset();
    test_round_robin();
    test_sole_requester();
    test_abort();
    test_live_tracking();
    test_no_gap();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/segmented_display_scheduler.md
Name: segmented_display_scheduler

Overview:
- Time-shares one segmented_display_driver among several requesters; each requester gets the display for a fixed dwell time, round-robin.
- Sits between client logic (status, counters, debug values) and the driver's data/dp inputs.
- Optional blank gap between owners so a viewer can see the ownership change.

Parameters:
- number_of_nybbles, 4, digits per frame; sets width of data and dp.
- number_of_requesters, 4, client count; must be ≥2.
- dwell_cycles, 50000000, clock cycles one owner holds the display; must be ≥1.
- blank_cycles, 5000000, clock cycles of idle pattern between owners; 0 means no gap state.
- idle_pattern, all-zero (number_of_nybbles*4 bits), data shown while idle or blanking.

Ports:
- clock  input  1  system clock.
- reset  input  1  reset, synchronous, active-high.
- req  input  number_of_requesters  level request; bit r held high while requester r wants the display.
- req_data  input  number_of_requesters*number_of_nybbles*4  packed nybbles; requester r occupies slice r.
- req_dp  input  number_of_requesters*number_of_nybbles  packed decimal points; requester r occupies slice r.
- grant  output  number_of_requesters  one-hot owner; all-zero when no owner.
- done  output  number_of_requesters  one-cycle pulse on the owner's bit when its full dwell expires.
- owner  output  $clog2(number_of_requesters)  index of the current or last owner.
- data  output  number_of_nybbles*4  to driver data input.
- dp  output  number_of_nybbles  to driver dp input.
- busy  output  1  high in SHOW and GAP.

Behaviour:
- Reset values:
  - grant=0, done=0, owner=0, busy=0, dp=0, data=idle_pattern.
  - Round-robin pointer=0, counter=0, state=IDLE.
- Reset asserted mid-SHOW or mid-GAP forces all reset values on the next edge. No done pulse is issued.
- All outputs are registered.
- State IDLE:
  - data=idle_pattern.
  - If any req bit is high, pick the first requesting index at or after the pointer, searching upward with wrap-around.
  - Next edge: grant[idx]=1, owner=idx, busy=1, counter=0, go to SHOW.
  - Grant latency from a req rising in IDLE is 1 cycle.
- State SHOW:
  - data/dp are registered copies of the owner's slice, updated every cycle (1-cycle latency, live tracking).
  - Counter increments each cycle.
  - When counter==dwell_cycles-1: done[owner] pulses for 1 cycle and grant clears on the same edge.
  - On that edge the pointer becomes owner+1, wrapping to 0 after number_of_requesters-1.
  - Next state is GAP, or IDLE if blank_cycles==0.
  - Abort: if req[owner] drops in SHOW, the next edge clears grant, pulses no done, advances the pointer as above, and enters GAP/IDLE.
  - If the abort and the dwell expiry fall on the same cycle, expiry wins and done is pulsed.
- State GAP:
  - data=idle_pattern, dp=0, busy=1, grant=0.
  - Counter runs 0..blank_cycles-1, then go to IDLE.
  - A new arbitration happens in IDLE the next cycle, so owner changes cost blank_cycles+1 cycles of non-ownership.
- Fairness:
  - A sole continuous requester is re-granted after every gap.
  - With all requesters active, the grant order is 0,1,2,…,R-1,0.
  - req changes during GAP are ignored until IDLE.
- Counter width: $clog2(max(dwell_cycles,blank_cycles)+1). The counter never wraps; it is cleared on every state entry.
- The output owner holds its value in IDLE/GAP; it is valid only while grant≠0.

Decomposition:
- Shared package segmented_display_pkg holds:
  - state encoding (IDLE, SHOW, GAP);
  - default idle_pattern constant;
  - a function for the round-robin next-requester search (masked priority with wrap).
- One natural sub-module: round_robin_picker, combinational. Inputs: req, pointer. Outputs: found, idx.
- The FSM, counter and output registers stay in the top.

Test Plan (number_of_requesters=3, number_of_nybbles=4, dwell_cycles=4, blank_cycles=2):
1. Reset, req=0 → grant=0, busy=0, data=idle_pattern indefinitely. Assert reset mid-SHOW → next cycle all outputs at reset values, no done.
2. req=3'b111 held, req_data slices 0x1111/0x2222/0x3333:
   - grant sequence 001,010,100,001, each held 4 cycles, separated by 3 non-granted cycles;
   - data follows the slices;
   - one done pulse per dwell.
3. Only req[1] held → grant=010 repeatedly, done[1] every 7 cycles, owner=1 throughout.
4. req[0] drops on the 2nd SHOW cycle → grant clears next edge, no done[0], then GAP, then grant goes to requester 1 if req[1]=1.
5. During SHOW of requester 2, change slice 2 from 0xABCD to 0x1234 → data shows 0x1234 one cycle later. req_dp slice 2 = 4'b0101 → dp=4'b0101 one cycle later.
6. blank_cycles=0 rebuild with req=3'b011 → grant goes 01→10 with exactly one IDLE cycle between, and busy drops for that cycle.
